pio_regs: RTL and testbench
===========================

// Module: pio_regs
// PURPOSE
//  PIO target of sap1; consumes the registered command stream from the host bridge.
//  Decodes pio_addr into control/status registers and the 16x8 SAP1 program RAM.
//  Returns read data with fixed 1-cycle latency; drives the CPU run/clear controls.
// PARAMETERS
//  ID_VALUE   32'h5A50_0001  value returned by the ID register
//  BAD_RDATA  32'hDEAD_BEEF  read data returned for unmapped addresses
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  pio_cmd_vld  in   1   command strobe, one command per cycle max, no backpressure
//  pio_rw       in   1   1=read, 0=write
//  pio_addr     in   16  byte address; [1:0] ignored
//  pio_data_w   in   32  write data
//  pio_rd_vld   out  1   read data valid, 1-cycle pulse per read
//  pio_data_r   out  32  read data, held until next read
//  cpu_run      out  1   CTRL.run level to CPU
//  cpu_clr      out  1   1-cycle clear pulse to CPU
//  cpu_halted   in   1   CPU executed HLT
//  cpu_pc       in   4   CPU program counter
//  cpu_out      in   8   CPU output register
//  mem_raddr    in   4   CPU program RAM read address
//  mem_rdata    out  8   CPU program RAM read data, registered (1-cycle latency)
// BEHAVIOUR
//  Register map (addr[15:2]); RO = writes ignored, no error:
//   0x0000 ID      RO  ID_VALUE
//   0x0004 SCRATCH RW  32b
//   0x0008 CTRL    RW  [0]=run; [1]=clr, write-1 pulses cpu_clr one cycle, reads 0
//   0x000C STATUS  RO  {27'b0, cpu_pc, cpu_halted}
//   0x0010 OUT     RO  {24'b0, cpu_out}
//   0x0014 CYCLES  RW  32b; +1 per cycle when run=1 && !cpu_halted; any write clears;
//                      wraps FFFF_FFFF->0; write and increment same cycle -> 0
//   0x0018 ERRCNT  RW  8b in [7:0], saturates at FF; any write clears; write wins over
//                      simultaneous increment
//   0x0100-0x013C RAM  entry = addr[5:2], data [7:0]; reads zero-extend
//  Any other address: read returns BAD_RDATA, write dropped; both increment ERRCNT.
//  RAM write while run=1: dropped, ERRCNT+1. RAM reads allowed anytime.
//  Read: cmd in cycle N -> pio_rd_vld=1 and pio_data_r valid in N+1; back-to-back
//   reads give back-to-back rd_vld. Writes produce no rd_vld; register updates at N+1.
//  Read of a register written in the previous cycle returns the new value.
//  RAM is dual-port, read-first: CPU read and PIO write same entry same cycle ->
//   mem_rdata returns old data; new data visible next cycle.
//  CTRL write with run=0 deasserts cpu_run at N+1; CYCLES stops counting that cycle.
//  Reset: pio_rd_vld=0, pio_data_r=0, SCRATCH=0, CTRL=0 (cpu_run=0, cpu_clr=0),
//   CYCLES=0, ERRCNT=0, mem_rdata=0; RAM contents not reset.
//  Reset mid-operation: a read issued the cycle reset is asserted gives no rd_vld.
//  Commands with pio_cmd_vld=0 have no effect regardless of other inputs.
// TESTING
//  1 reset, read 0x0000 -> rd_vld one cycle later, data 5A50_0001; read 0x0008 -> 0
//  2 write 0x0004=1234_5678, next cycle read 0x0004 -> 1234_5678; back-to-back reads
//    0x0000,0x0004 -> two consecutive rd_vld, data in order
//  3 write RAM 0x0104=0xA5 (run=0), mem_raddr=1 -> mem_rdata A5 next cycle;
//    PIO read 0x0104 -> 0000_00A5
//  4 write CTRL=1, then RAM write 0x0108=0x3C -> dropped, ERRCNT=1; read 0x0FF0 ->
//    DEAD_BEEF, ERRCNT=2; 300 bad accesses -> ERRCNT=FF
//  5 CTRL=1, cpu_halted=0 for 10 cycles, then cpu_halted=1 -> CYCLES=10 and frozen;
//    write CYCLES -> 0; write CTRL=2 -> cpu_clr high exactly one cycle, run=0
//  6 issue read then assert reset next cycle -> rd_vld still occurs once; read issued
//    during reset -> no rd_vld; all regs at reset values after

Source files
------------

// File: rtl/pio_regs.sv
// PIO register target for the SAP1 core: control/status registers, cycle and
// error counters, and the 16x8 program RAM shared with the CPU fetch port.
module pio_regs #(
  parameter logic [31:0] ID_VALUE  = 32'h5A50_0001,
  parameter logic [31:0] BAD_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pio_cmd_vld,
  input  logic        pio_rw,
  input  logic [15:0] pio_addr,
  input  logic [31:0] pio_data_w,
  output logic        pio_rd_vld,
  output logic [31:0] pio_data_r,
  output logic        cpu_run,
  output logic        cpu_clr,
  input  logic        cpu_halted,
  input  logic [3:0]  cpu_pc,
  input  logic [7:0]  cpu_out,
  input  logic [3:0]  mem_raddr,
  output logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    R_ID      = 3'd0,
    R_SCRATCH = 3'd1,
    R_CTRL    = 3'd2,
    R_STATUS  = 3'd3,
    R_OUT     = 3'd4,
    R_CYCLES  = 3'd5,
    R_ERRCNT  = 3'd6,
    R_NONE    = 3'd7
  } reg_e;

  logic [7:0]  ram [16];
  logic [31:0] scratch;
  logic [31:0] cycles;
  logic [7:0]  errcnt;
  logic        run;
  logic        clr;

  logic        rd_cmd;
  logic        wr_cmd;
  logic        ram_hit;
  logic [3:0]  ram_idx;
  reg_e        sel;
  logic        reg_hit;
  logic        bad;
  logic        ram_we;
  logic [31:0] rdata;
  logic        unused;

  assign unused  = ^pio_addr[1:0];

  assign rd_cmd  = pio_cmd_vld & pio_rw;
  assign wr_cmd  = pio_cmd_vld & ~pio_rw;
  assign ram_hit = (pio_addr[15:6] == 10'h004);
  assign ram_idx = pio_addr[5:2];
  assign sel     = (pio_addr[15:5] == 11'd0) ? reg_e'(pio_addr[4:2]) : R_NONE;
  assign reg_hit = (sel != R_NONE);

  // Unmapped accesses and RAM writes while the CPU runs are both counted as errors.
  assign bad     = pio_cmd_vld & ((~ram_hit & ~reg_hit) | (ram_hit & ~pio_rw & run));
  assign ram_we  = wr_cmd & ram_hit & ~run & ~reset;

  assign cpu_run = run;
  assign cpu_clr = clr;

  always_comb begin
    rdata = BAD_RDATA;
    if (ram_hit) begin
      rdata = {24'd0, ram[ram_idx]};
    end else begin
      case (sel)
        R_ID:      rdata = ID_VALUE;
        R_SCRATCH: rdata = scratch;
        R_CTRL:    rdata = {31'd0, run};
        R_STATUS:  rdata = {27'd0, cpu_pc, cpu_halted};
        R_OUT:     rdata = {24'd0, cpu_out};
        R_CYCLES:  rdata = cycles;
        R_ERRCNT:  rdata = {24'd0, errcnt};
        default:   rdata = BAD_RDATA;
      endcase
    end
  end

  // RAM is not reset; nonblocking read of the CPU port gives read-first ordering.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= pio_data_w[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) mem_rdata <= 8'd0;
    else       mem_rdata <= ram[mem_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pio_rd_vld <= 1'b0;
      pio_data_r <= 32'd0;
      scratch    <= 32'd0;
      run        <= 1'b0;
      clr        <= 1'b0;
      cycles     <= 32'd0;
      errcnt     <= 8'd0;
    end else begin
      pio_rd_vld <= rd_cmd;
      if (rd_cmd) pio_data_r <= rdata;

      if (wr_cmd && sel == R_SCRATCH) scratch <= pio_data_w;

      clr <= wr_cmd && sel == R_CTRL && pio_data_w[1];
      if (wr_cmd && sel == R_CTRL) run <= pio_data_w[0];

      if (wr_cmd && sel == R_CYCLES)  cycles <= 32'd0;
      else if (run && !cpu_halted)    cycles <= cycles + 32'd1;

      if (wr_cmd && sel == R_ERRCNT)  errcnt <= 8'd0;
      else if (bad && errcnt != 8'hFF) errcnt <= errcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pio_regs.sv
// Bench for pio_regs: directed scenarios with literal checks plus a random phase,
// all outputs compared every cycle against a command-level reference model.
module tb_pio_regs;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pio_cmd_vld = 1'b0;
  logic        pio_rw = 1'b0;
  logic [15:0] pio_addr = 16'd0;
  logic [31:0] pio_data_w = 32'd0;
  logic        pio_rd_vld;
  logic [31:0] pio_data_r;
  logic        cpu_run;
  logic        cpu_clr;
  logic        cpu_halted = 1'b0;
  logic [3:0]  cpu_pc = 4'd5;
  logic [7:0]  cpu_out = 8'h3C;
  logic [3:0]  mem_raddr = 4'd0;
  logic [7:0]  mem_rdata;

  pio_regs dut (
    .clk(clk), .reset(reset),
    .pio_cmd_vld(pio_cmd_vld), .pio_rw(pio_rw), .pio_addr(pio_addr),
    .pio_data_w(pio_data_w), .pio_rd_vld(pio_rd_vld), .pio_data_r(pio_data_r),
    .cpu_run(cpu_run), .cpu_clr(cpu_clr), .cpu_halted(cpu_halted),
    .cpu_pc(cpu_pc), .cpu_out(cpu_out), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state of the register file as seen by a PIO master.
  bit          m_vld = 1'b0;
  logic [31:0] m_data = 32'd0;
  bit          m_data_ok = 1'b1;
  logic [31:0] m_scratch = 32'd0;
  logic [31:0] m_cycles = 32'd0;
  int          m_err = 0;
  bit          m_run = 1'b0;
  bit          m_clr = 1'b0;
  logic [7:0]  m_mem = 8'd0;
  bit          m_mem_ok = 1'b1;
  logic [7:0]  m_ram [16];
  bit          m_known [16];

  initial for (int i = 0; i < 16; i++) m_known[i] = 1'b0;

  always @(posedge clk) begin : model
    logic [15:0] a;
    logic [31:0] rv;
    logic [31:0] nxt_cyc;
    bit rok, bad, err_clr;
    int idx;
    if (reset) begin
      m_vld = 0; m_data = 0; m_data_ok = 1; m_scratch = 0; m_run = 0; m_clr = 0;
      m_cycles = 0; m_err = 0; m_mem = 0; m_mem_ok = 1;
    end else begin
      m_mem = m_ram[mem_raddr];
      m_mem_ok = m_known[mem_raddr];
      nxt_cyc = (m_run && !cpu_halted) ? m_cycles + 32'd1 : m_cycles;
      bad = 0; err_clr = 0; rok = 1; rv = 32'hDEAD_BEEF;
      m_clr = 0;
      m_vld = 0;
      if (pio_cmd_vld) begin
        a = pio_addr & 16'hFFFC;
        if (a >= 16'h0100 && a <= 16'h013C) begin
          idx = int'(a - 16'h0100) / 4;
          if (pio_rw) begin
            rv = {24'd0, m_ram[idx]};
            rok = m_known[idx];
          end else if (m_run) begin
            bad = 1;
          end else begin
            m_ram[idx] = pio_data_w[7:0];
            m_known[idx] = 1;
          end
        end else begin
          case (a)
            16'h0000: rv = 32'h5A50_0001;
            16'h0004: begin rv = m_scratch; if (!pio_rw) m_scratch = pio_data_w; end
            16'h0008: begin
              rv = {31'd0, m_run};
              if (!pio_rw) begin m_run = pio_data_w[0]; m_clr = pio_data_w[1]; end
            end
            16'h000C: rv = {27'd0, cpu_pc, cpu_halted};
            16'h0010: rv = {24'd0, cpu_out};
            16'h0014: begin rv = m_cycles; if (!pio_rw) nxt_cyc = 0; end
            16'h0018: begin rv = 32'(m_err); if (!pio_rw) err_clr = 1; end
            default:  bad = 1;
          endcase
        end
        if (pio_rw) begin m_vld = 1; m_data = rv; m_data_ok = rok; end
      end
      m_cycles = nxt_cyc;
      if (err_clr) m_err = 0;
      else if (bad && m_err < 255) m_err = m_err + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd_vld", 32'(pio_rd_vld), 32'(m_vld));
      if (m_data_ok) chk("data_r", pio_data_r, m_data);
      chk("cpu_run", 32'(cpu_run), 32'(m_run));
      chk("cpu_clr", 32'(cpu_clr), 32'(m_clr));
      if (m_mem_ok) chk("mem_rdata", 32'(mem_rdata), 32'(m_mem));
    end
  end

  task automatic issue(input bit rw, input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pio_cmd_vld = 1'b1; pio_rw = rw; pio_addr = a; pio_data_w = d;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    pio_cmd_vld = 1'b0;
  endtask

  // Single read, then check the response in the following cycle.
  task automatic rd_chk(input string name, input logic [15:0] a, input logic [31:0] exp);
    issue(1'b1, a, 32'd0);
    idle();
    @(negedge clk);
    chk({name, "_vld"}, 32'(pio_rd_vld), 32'd1);
    chk(name, pio_data_r, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) issue(1'b0, 16'(16'h0100 + i * 4), $urandom);
    idle();

    // reset values and ID
    @(negedge clk);
    chk("rst_rd_vld", 32'(pio_rd_vld), 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    rd_chk("id", 16'h0000, 32'h5A50_0001);
    rd_chk("ctrl_rst", 16'h0008, 32'd0);
    rd_chk("status", 16'h000C, 32'h0000_000A);
    rd_chk("out", 16'h0010, 32'h0000_003C);

    // write then immediate read; back-to-back reads
    issue(1'b0, 16'h0004, 32'h1234_5678);
    rd_chk("scratch", 16'h0004, 32'h1234_5678);
    issue(1'b1, 16'h0000, 32'd0);
    issue(1'b1, 16'h0006, 32'd0);
    @(negedge clk);
    chk("b2b0_vld", 32'(pio_rd_vld), 32'd1);
    chk("b2b0", pio_data_r, 32'h5A50_0001);
    idle();
    @(negedge clk);
    chk("b2b1_vld", 32'(pio_rd_vld), 32'd1);
    chk("b2b1", pio_data_r, 32'h1234_5678);

    // RAM via PIO and CPU port, including same-entry read-first
    issue(1'b0, 16'h0104, 32'h0000_00A5);
    idle();
    mem_raddr = 4'd1;
    idle();
    @(negedge clk);
    chk("mem_a5", 32'(mem_rdata), 32'hA5);
    rd_chk("ram_rd", 16'h0104, 32'h0000_00A5);
    mem_raddr = 4'd3;
    issue(1'b0, 16'h010C, 32'h0000_0077);
    idle();
    idle();
    @(negedge clk);
    chk("mem_new", 32'(mem_rdata), 32'h77);

    // error counting and saturation
    issue(1'b0, 16'h0018, 32'd0);
    issue(1'b0, 16'h0008, 32'd1);
    issue(1'b0, 16'h0108, 32'h0000_003C);
    rd_chk("err1", 16'h0018, 32'd1);
    rd_chk("bad_rd", 16'h0FF0, 32'hDEAD_BEEF);
    rd_chk("err2", 16'h0018, 32'd2);
    repeat (300) issue(1'b0, 16'h0FF0, $urandom);
    rd_chk("err_sat", 16'h0018, 32'h0000_00FF);

    // cycle counter: 10 counting cycles then halted
    cpu_halted = 1'b0;
    issue(1'b0, 16'h0008, 32'd0);
    issue(1'b0, 16'h0014, 32'd0);
    issue(1'b0, 16'h0008, 32'd1);
    repeat (10) idle();
    issue(1'b1, 16'h0014, 32'd0);
    cpu_halted = 1'b1;
    idle();
    @(negedge clk);
    chk("cycles10", pio_data_r, 32'd10);
    repeat (5) idle();
    rd_chk("cycles_frozen", 16'h0014, 32'd10);
    issue(1'b0, 16'h0014, 32'hFFFF_FFFF);
    rd_chk("cycles_clr", 16'h0014, 32'd0);
    issue(1'b0, 16'h0008, 32'd2);
    idle();
    @(negedge clk);
    chk("clr_pulse", 32'(cpu_clr), 32'd1);
    chk("clr_run", 32'(cpu_run), 32'd0);
    @(negedge clk);
    chk("clr_end", 32'(cpu_clr), 32'd0);
    rd_chk("ctrl_clr_rd", 16'h0008, 32'd0);

    // reset during operation
    cpu_halted = 1'b0;
    issue(1'b0, 16'h0004, 32'h0000_CAFE);
    issue(1'b0, 16'h0008, 32'd1);
    issue(1'b1, 16'h0000, 32'd0);
    @(posedge clk); #1;
    pio_cmd_vld = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_pending_vld", 32'(pio_rd_vld), 32'd1);
    @(posedge clk); #1;
    pio_cmd_vld = 1'b1; pio_rw = 1'b1; pio_addr = 16'h0000;
    @(posedge clk); #1;
    pio_cmd_vld = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("rst_drop_vld", 32'(pio_rd_vld), 32'd0);
    chk("rst_run2", 32'(cpu_run), 32'd0);
    rd_chk("rst_scratch", 16'h0004, 32'd0);
    rd_chk("rst_cycles", 16'h0014, 32'd0);
    rd_chk("rst_err", 16'h0018, 32'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int sel;
      logic [15:0] a;
      @(posedge clk); #1;
      sel = int'($urandom_range(0, 9));
      if (sel < 5)      a = 16'($urandom_range(0, 7) * 4);
      else if (sel < 8) a = 16'(16'h0100 + $urandom_range(0, 15) * 4);
      else if (sel == 8) a = 16'($urandom);
      else begin
        case ($urandom_range(0, 2))
          0: a = 16'h0140;
          1: a = 16'h00FC;
          default: a = 16'h0020;
        endcase
      end
      a[1:0] = 2'($urandom);
      reset       = ($urandom_range(0, 299) == 0);
      pio_cmd_vld = ($urandom_range(0, 3) != 0);
      pio_rw      = 1'($urandom);
      pio_addr    = a;
      pio_data_w  = $urandom;
      cpu_halted  = ($urandom_range(0, 3) == 0);
      cpu_pc      = 4'($urandom);
      cpu_out     = 8'($urandom);
      mem_raddr   = 4'($urandom);
    end
    @(posedge clk); #1;
    pio_cmd_vld = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
